// File: rtl/mult_pkg.sv
// mult_pkg
// Shared types for the radix-4 Booth multiplier:
//   state_t       - sequencer states (IDLE, CALC, DONE)
//   booth_digit_t - recoded multiplier digit (0, +1, +2, -1, -2)
//   booth_decode  - maps three overlapping multiplier bits to a digit
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_t;

    // Bits are {y[2i+1], y[2i], y[2i-1]}; digit = -2*y[2i+1] + y[2i] + y[2i-1].
    function automatic booth_digit_t booth_decode(input logic [2:0] bits);
        booth_digit_t d;
        case (bits)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// booth_r4_encoder
// Purely combinational radix-4 Booth recoder and partial-product selector.
// Ports:
//   bits  [2:0]        - three overlapping multiplier bits (LSB is the bit
//                        below the current pair)
//   mcand [WIDTH+1:0]  - multiplicand already extended to WIDTH+2 bits
//   pp    [WIDTH+1:0]  - selected partial product d*M, two's complement
module booth_r4_encoder
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       bits,
    input  logic [WIDTH+1:0] mcand,
    output logic [WIDTH+1:0] pp
);

    booth_digit_t     digit;
    logic [WIDTH+1:0] mcand_x2;

    // Doubling cannot overflow: the extended operand carries two spare MSBs.
    assign mcand_x2 = {mcand[WIDTH:0], 1'b0};

    always_comb begin
        digit = booth_decode(bits);
    end

    always_comb begin
        pp = '0;
        unique case (digit)
            ZERO: pp = '0;
            POS1: pp = mcand;
            POS2: pp = mcand_x2;
            NEG1: pp = -mcand;
            NEG2: pp = -mcand_x2;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// booth_radix4_multiplier
// Sequential radix-4 Booth multiplier, signed or unsigned, one digit per
// clock. Operands are captured on start in IDLE; WIDTH/2+1 CALC cycles
// later the exact 2*WIDTH-bit product is registered and done pulses.
// Ports:
//   clk          - clock, rising edge
//   rst          - synchronous active-low reset
//   start        - request, honoured only in IDLE
//   signed_mode  - 1: two's complement operands, 0: unsigned
//   a, b         - multiplicand / multiplier, sampled with start
//   busy         - high throughout CALC
//   done         - one-cycle pulse when product has just been updated
//   product      - last completed result, held between completions
module booth_radix4_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int XW    = WIDTH + 2;
    localparam int CNT_W = $clog2(WIDTH / 2 + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH / 2);

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] a_reg;
    logic             signed_reg;
    logic [XW-1:0]    acc;
    logic [XW:0]      mreg;        // extended multiplier plus implicit LSB 0
    logic [CNT_W-1:0] cnt;

    logic [XW-1:0]    mcand;
    logic [XW-1:0]    b_ext;
    logic [XW-1:0]    pp;
    logic [XW-1:0]    sum;
    logic [XW-1:0]    acc_shift;
    logic [XW:0]      mreg_shift;
    logic             capture;
    logic             last_step;

    assign capture   = (state == IDLE) && start;
    assign last_step = (state == CALC) && (cnt == LAST_STEP);

    assign mcand = signed_reg ? {{2{a_reg[WIDTH-1]}}, a_reg} : {2'b00, a_reg};
    assign b_ext = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

    booth_r4_encoder #(
        .WIDTH (WIDTH)
    ) u_encoder (
        .bits  (mreg[2:0]),
        .mcand (mcand),
        .pp    (pp)
    );

    // One Booth step: add d*M to the upper half, then arithmetic-shift the
    // concatenation {acc, mreg} right by two. The partial sums stay within
    // [-2^(WIDTH+1), 2^(WIDTH+1)), so XW bits never overflow.
    assign sum        = acc + pp;
    assign acc_shift  = {{2{sum[XW-1]}}, sum[XW-1:2]};
    assign mreg_shift = {sum[1:0], mreg[XW:2]};

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (last_step) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE:    ;
            CALC:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg      <= '0;
            signed_reg <= 1'b0;
            acc        <= '0;
            mreg       <= '0;
            cnt        <= '0;
            product    <= '0;
        end else if (capture) begin
            a_reg      <= a;
            signed_reg <= signed_mode;
            mreg       <= {b_ext, 1'b0};
            acc        <= '0;
            cnt        <= '0;
        end else if (state == CALC) begin
            acc  <= acc_shift;
            mreg <= mreg_shift;
            cnt  <= cnt + CNT_W'(1);
            // After the final shift the full product sits in {acc, mreg[XW:1]};
            // only its low 2*WIDTH bits are meaningful.
            if (last_step) begin
                product <= {acc_shift[WIDTH-3:0], mreg_shift[XW:1]};
            end
        end
    end

endmodule

// File: doc/booth_radix4_multiplier.md
BOOTH_RADIX4_MULTIPLIER -- requirements
Module: booth_radix4_multiplier

Interface
REQ-001 Parameter WIDTH, default 32, operand width; SHALL be even and >= 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low (rst=0 resets on the next rising clk edge).
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 signed_mode  input  1  1: a, b two's complement; 0: a, b unsigned; sampled with start.
REQ-006 a  input  WIDTH  multiplicand; sampled with start.
REQ-007 b  input  WIDTH  multiplier; sampled with start.
REQ-008 busy  output  1  high while in CALC.
REQ-009 done  output  1  one-cycle pulse: product just updated.
REQ-010 product  output  2*WIDTH  last completed result, registered.

Function
REQ-011 FSM states SHALL be IDLE, CALC and DONE.
REQ-012 Transitions: IDLE->CALC on start=1; CALC->DONE after the last iteration; DONE->IDLE unconditionally.
REQ-013 On the capture edge, a, b and signed_mode SHALL be registered.
REQ-014 On the capture edge, the accumulator SHALL clear and the iteration counter SHALL clear.
REQ-015 The multiplier SHALL be extended to WIDTH+2 bits plus an implicit LSB 0, sign-extended if signed_mode=1, else zero-extended.
REQ-016 The multiplicand M SHALL be extended to WIDTH+2 bits, sign-extended if signed_mode=1, else zero-extended.
REQ-017 Each CALC cycle SHALL perform one radix-4 step: select digit d in {-2,-1,0,+1,+2} from 3 overlapping multiplier bits.
REQ-018 Each CALC step SHALL add d*M to the upper accumulator half (WIDTH+2 bits, no overflow possible).
REQ-019 Each CALC step SHALL then arithmetic-shift the combined accumulator/multiplier right by 2.
REQ-020 CALC SHALL last exactly WIDTH/2+1 cycles (17 for WIDTH=32), identical in both modes.
REQ-021 On the final CALC edge, product SHALL load the low 2*WIDTH bits of the exact result, and the state SHALL become DONE.
REQ-022 done=1 exactly in DONE, for one cycle, WIDTH/2+1 cycles after the capture edge.
REQ-023 busy SHALL be 0 in IDLE and DONE.
REQ-024 start while in CALC or DONE SHALL be ignored; there is no queuing.
REQ-025 Operand changes after capture SHALL not affect the result.
REQ-026 start=1 in the IDLE cycle following DONE SHALL be accepted, so the back-to-back period is WIDTH/2+3 cycles.
REQ-027 product SHALL hold its value between completions; it SHALL not change during CALC.
REQ-028 Signed result = a*b as two's complement 2*WIDTH; unsigned result = a*b as unsigned 2*WIDTH; both exact for all inputs, including most-negative*most-negative.

Reset
REQ-029 With rst=0 at a clock edge, regardless of state, the state SHALL go to IDLE and busy and done SHALL go to 0.
REQ-030 With rst=0 at a clock edge, product, the accumulator, the counter and the operand registers SHALL all go to 0.
REQ-031 Reset during CALC SHALL abort the operation; no done pulse and no product update for it.
REQ-032 rst=0 together with start=1 SHALL give reset priority.

Structure
REQ-033 Shared package mult_pkg SHALL hold the FSM state type (IDLE, CALC, DONE).
REQ-034 mult_pkg SHALL also hold the Booth digit encoding type (ZERO, POS1, POS2, NEG1, NEG2).
REQ-035 One combinational sub-module booth_r4_encoder SHALL map 3 multiplier bits to a digit and the digit plus M to a (WIDTH+2)-bit partial product.
REQ-036 All state SHALL be in booth_radix4_multiplier; no latches.

Verification (WIDTH=32)
REQ-037 Signed: a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0x0000000000000001; done exactly 17 cycles after capture, width 1 cycle.
REQ-038 Unsigned: a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001; signed a=b=0x80000000 -> 0x4000000000000000.
REQ-039 Signed: a=7, b=0xFFFFFFFD (-3) -> product=0xFFFFFFFFFFFFFFEB; unsigned same operands -> 0x00000006FFFFFFEB.
REQ-040 start pulsed with new operands in CALC cycle 5 -> ignored, result of the first operands only, single done pulse.
REQ-041 rst=0 in CALC cycle 8 -> next cycle busy=0, done=0, product=0; no done afterwards until a new start.
REQ-042 start held high continuously with changing operands -> successive results every 19 cycles, each matching the operands present at its capture edge.
